// File: rtl/fx_mac_seq.sv
// Operand sequencer for fx_mac: buffers one weight and one data vector, streams them as a
// contiguous K-cycle burst per start, then captures the result pulse or flags a lost result.
module fx_mac_seq #(
  parameter int WIDTH   = 8,
  parameter int K       = 9,
  parameter int TIMEOUT = 32,
  localparam int AW     = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic             wr_sel_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] win_o,
  output logic [WIDTH-1:0] din_o,
  output logic             vld_o,
  input  logic [WIDTH-1:0] acc_i,
  input  logic             acc_vld_i,
  output logic [WIDTH-1:0] result_o,
  output logic             done_o,
  output logic             timeout_o
);

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [AW:0]   K_L      = (AW + 1)'(K);
  localparam logic [AW-1:0] IDX_LAST = AW'(K - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [AW-1:0]    idx_reg, idx_next;
  logic [TW-1:0]    timer_reg, timer_next;
  logic             vld_reg, vld_next;
  logic [WIDTH-1:0] win_reg, win_next;
  logic [WIDTH-1:0] din_reg, din_next;
  logic             busy_reg, busy_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             done_reg, done_next;
  logic             timeout_reg, timeout_next;
  logic             wr_ok;

  logic [WIDTH-1:0] wbuf_reg [K];
  logic [WIDTH-1:0] dbuf_reg [K];
  logic [K-1:0]     wsel_w;
  logic [K-1:0]     dsel_w;

  // Per-element write decode; out-of-range addresses match no element.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_wdec
      assign wsel_w[gi] = wr_ok && !wr_sel_i && (wr_addr_i == AW'(gi));
      assign dsel_w[gi] = wr_ok &&  wr_sel_i && (wr_addr_i == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      for (int i = 0; i < K; i++) begin
        wbuf_reg[i] <= '0;
        dbuf_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < K; i++) begin
        if (wsel_w[i]) wbuf_reg[i] <= wr_data_i;
        if (dsel_w[i]) dbuf_reg[i] <= wr_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      timer_reg   <= '0;
      vld_reg     <= 1'b0;
      win_reg     <= '0;
      din_reg     <= '0;
      busy_reg    <= 1'b0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      timer_reg   <= timer_next;
      vld_reg     <= vld_next;
      win_reg     <= win_next;
      din_reg     <= din_next;
      busy_reg    <= busy_next;
      result_reg  <= result_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
    end
  end

  // Outputs are the registered image of the current state's decision, so vld_o and busy_o
  // lag the state by one cycle; busy_o drops together with done_o/timeout_o.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    timer_next   = timer_reg;
    vld_next     = 1'b0;
    win_next     = '0;
    din_next     = '0;
    busy_next    = 1'b0;
    result_next  = result_reg;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    wr_ok        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        wr_ok = wr_en_i && ({1'b0, wr_addr_i} < K_L);
        if (start_i) begin
          state_next = ST_ISSUE;
          idx_next   = '0;
        end
      end
      ST_ISSUE: begin
        vld_next  = 1'b1;
        win_next  = wbuf_reg[idx_reg];
        din_next  = dbuf_reg[idx_reg];
        busy_next = 1'b1;
        if (idx_reg == IDX_LAST) begin
          state_next = ST_WAIT;
          timer_next = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      ST_WAIT: begin
        busy_next = 1'b1;
        if (acc_vld_i) begin
          result_next = acc_i;
          done_next   = 1'b1;
          busy_next   = 1'b0;
          state_next  = ST_IDLE;
        end else if (timer_reg == TMR_LAST) begin
          timeout_next = 1'b1;
          busy_next    = 1'b0;
          state_next   = ST_IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy_o    = busy_reg;
  assign vld_o     = vld_reg;
  assign win_o     = win_reg;
  assign din_o     = din_reg;
  assign result_o  = result_reg;
  assign done_o    = done_reg;
  assign timeout_o = timeout_reg;

endmodule

// File: tb/tb_fx_mac_seq.sv
// Directed bench for fx_mac_seq: K=4 main instance plus a K=5 instance for out-of-range writes.
module tb_fx_mac_seq;

  logic       clk_i = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en_i = 1'b0, wr_en5 = 1'b0;
  logic       wr_sel_i = 1'b0;
  logic [1:0] wr_addr_i = '0;
  logic [2:0] wr_addr5 = '0;
  logic [7:0] wr_data_i = '0;
  logic       start_i = 1'b0, start5 = 1'b0;
  logic [7:0] acc_i = '0;
  logic       acc_vld_i = 1'b0;

  logic       busy_o, vld_o, done_o, timeout_o;
  logic [7:0] win_o, din_o, result_o;
  logic       busy5, vld5, done5, timeout5;
  logic [7:0] win5, din5, result5;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  fx_mac_seq #(.WIDTH(8), .K(4), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rstn(rstn), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .start_i(start_i), .busy_o(busy_o),
    .win_o(win_o), .din_o(din_o), .vld_o(vld_o), .acc_i(acc_i), .acc_vld_i(acc_vld_i),
    .result_o(result_o), .done_o(done_o), .timeout_o(timeout_o)
  );

  fx_mac_seq #(.WIDTH(8), .K(5), .TIMEOUT(8)) dut5 (
    .clk_i(clk_i), .rstn(rstn), .wr_en_i(wr_en5), .wr_sel_i(wr_sel_i),
    .wr_addr_i(wr_addr5), .wr_data_i(wr_data_i), .start_i(start5), .busy_o(busy5),
    .win_o(win5), .din_o(din5), .vld_o(vld5), .acc_i(acc_i), .acc_vld_i(acc_vld_i),
    .result_o(result5), .done_o(done5), .timeout_o(timeout5)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [1:0] addr, input logic [7:0] data);
    wr_en_i = 1'b1; wr_sel_i = sel; wr_addr_i = addr; wr_data_i = data;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic wr5(input logic sel, input logic [2:0] addr, input logic [7:0] data);
    wr_en5 = 1'b1; wr_sel_i = sel; wr_addr5 = addr; wr_data_i = data;
    tick();
    wr_en5 = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({vld_o, busy_o, done_o, timeout_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {vld_o, busy_o, done_o, timeout_o});
    end
    checks++;
    if ({win_o, din_o, result_o} !== 24'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=000000", {win_o, din_o, result_o});
    end
    rstn = 1'b1;
    tick();
    $display("reset: released");
  endtask

  // Last data write shares its cycle with start_i: the burst must carry the new value.
  task automatic test_basic();
    for (int i = 0; i < 4; i++) wr(1'b0, 2'(i), 8'd16);
    for (int i = 0; i < 3; i++) wr(1'b1, 2'(i), 8'(i + 1));
    wr_en_i = 1'b1; wr_sel_i = 1'b1; wr_addr_i = 2'd3; wr_data_i = 8'd4; start_i = 1'b1;
    tick();
    wr_en_i = 1'b0; start_i = 1'b0;
    checks++;
    if (vld_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_c0 vld/busy got=%b%b want=00", vld_o, busy_o);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (vld_o !== 1'b1 || busy_o !== 1'b1 || win_o !== 8'd16 || din_o !== 8'(c)) begin
        failures++;
        $display("FAIL basic_pair c=%0d got vld=%b busy=%b w=%0d d=%0d want 1 1 16 %0d",
                 c, vld_o, busy_o, win_o, din_o, c);
      end
    end
    for (int c = 5; c <= 10; c++) begin
      tick();
      checks++;
      if (vld_o !== 1'b0 || busy_o !== 1'b1 || win_o !== 8'd0 || din_o !== 8'd0 || done_o !== 1'b0) begin
        failures++;
        $display("FAIL basic_wait c=%0d got vld=%b busy=%b w=%0d d=%0d done=%b want 0 1 0 0 0",
                 c, vld_o, busy_o, win_o, din_o, done_o);
      end
      if (c == 10) begin acc_vld_i = 1'b1; acc_i = 8'h0A; end
    end
    tick();
    acc_vld_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || result_o !== 8'h0A || busy_o !== 1'b0 || timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got done=%b res=%h busy=%b to=%b want 1 0a 0 0",
               done_o, result_o, busy_o, timeout_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || result_o !== 8'h0A) begin
      failures++;
      $display("FAIL basic_hold got done=%b res=%h want 0 0a", done_o, result_o);
    end
    $display("basic: pass with pairs (16,1..4) result=%h", result_o);
  endtask

  task automatic test_timeout();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if (timeout_o !== (c == 12) || done_o !== 1'b0 || busy_o !== (c < 12)) begin
        failures++;
        $display("FAIL timeout_seq c=%0d got to=%b done=%b busy=%b want %b 0 %b",
                 c, timeout_o, done_o, busy_o, c == 12, c < 12);
      end
    end
    checks++;
    if (result_o !== 8'h0A) begin
      failures++;
      $display("FAIL timeout_result got=%h want=0a", result_o);
    end
    tick();
    checks++;
    if (timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse got=%b want=0", timeout_o);
    end
    $display("timeout: pulse at WAIT+8, result held %h", result_o);
  endtask

  // Held start: passes repeat every 13 cycles (4 issue + 8 wait + 1 idle).
  task automatic test_start_held();
    int rises = 0;
    logic prev = 1'b0;
    logic exp;
    start_i = 1'b1;
    for (int c = 0; c <= 25; c++) begin
      tick();
      exp = (c >= 1 && c <= 4) || (c >= 14 && c <= 17);
      checks++;
      if (vld_o !== exp) begin
        failures++;
        $display("FAIL held_vld c=%0d got=%b want=%b", c, vld_o, exp);
      end
      if (vld_o && !prev) rises++;
      prev = vld_o;
    end
    start_i = 1'b0;
    checks++;
    if (rises != 2) begin
      failures++;
      $display("FAIL held_bursts got=%0d want=2", rises);
    end
    tick();
    $display("start_held: %0d bursts in 26 cycles", rises);
  endtask

  task automatic test_busy_writes();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      wr_en_i = (c == 1) || (c == 6);
      wr_sel_i = (c == 6);
      wr_addr_i = 2'd0;
      wr_data_i = 8'h7F;
      if (c == 10) begin acc_vld_i = 1'b1; acc_i = 8'h0A; end
    end
    tick();
    acc_vld_i = 1'b0;
    wr_en_i = 1'b0;
    checks++;
    if (done_o !== 1'b1) begin
      failures++;
      $display("FAIL busywr_done got=%b want=1", done_o);
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (vld_o !== 1'b1 || win_o !== 8'd16 || din_o !== 8'(c)) begin
        failures++;
        $display("FAIL busywr_pair c=%0d got vld=%b w=%h d=%h want 1 10 %h", c, vld_o, win_o, din_o, c);
      end
    end
    repeat (6) tick();
    acc_vld_i = 1'b1; acc_i = 8'h0A;
    tick();
    acc_vld_i = 1'b0;
    tick();
    $display("busy_writes: buffers unchanged after writes while busy");
  endtask

  // acc_vld_i sampled on the same edge where the timer expires.
  task automatic test_coincident();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 11; c++) tick();
    acc_vld_i = 1'b1; acc_i = 8'h33;
    tick();
    acc_vld_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || timeout_o !== 1'b0 || result_o !== 8'h33) begin
      failures++;
      $display("FAIL coincident got done=%b to=%b res=%h want 1 0 33", done_o, timeout_o, result_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL coincident_after got done=%b to=%b want 0 0", done_o, timeout_o);
    end
    $display("coincident: result=%h captured, no timeout", result_o);
  endtask

  task automatic test_range();
    logic [7:0] w_exp [5] = '{8'd0, 8'd5, 8'd0, 8'd0, 8'd3};
    logic [7:0] d_exp [5] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd2};
    wr5(1'b0, 3'd4, 8'd3);
    wr5(1'b1, 3'd4, 8'd2);
    wr5(1'b0, 3'd1, 8'd5);
    wr5(1'b0, 3'd5, 8'h7F);
    wr5(1'b1, 3'd7, 8'h7F);
    wr5(1'b0, 3'd6, 8'h7F);
    start5 = 1'b1;
    tick();
    start5 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if (vld5 !== 1'b1 || win5 !== w_exp[c-1] || din5 !== d_exp[c-1]) begin
        failures++;
        $display("FAIL range_pair c=%0d got vld=%b w=%h d=%h want 1 %h %h",
                 c, vld5, win5, din5, w_exp[c-1], d_exp[c-1]);
      end
    end
    for (int c = 6; c <= 13; c++) tick();
    checks++;
    if (timeout5 !== 1'b1 || vld5 !== 1'b0) begin
      failures++;
      $display("FAIL range_timeout got to=%b vld=%b want 1 0", timeout5, vld5);
    end
    tick();
    $display("range: K=5 writes at addr>=5 dropped");
  endtask

  task automatic test_reset_abort();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    checks++;
    if (vld_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_edge got vld=%b busy=%b done=%b want 0 0 0", vld_o, busy_o, done_o);
    end
    rstn = 1'b1;
    acc_vld_i = 1'b1; acc_i = 8'h55;
    tick();
    acc_vld_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (done_o !== 1'b0 || timeout_o !== 1'b0 || result_o !== 8'h00 || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL abort_idle got done=%b to=%b res=%h busy=%b want 0 0 00 0",
                 done_o, timeout_o, result_o, busy_o);
      end
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (vld_o !== 1'b1 || win_o !== 8'd0 || din_o !== 8'd0) begin
        failures++;
        $display("FAIL abort_cleared c=%0d got vld=%b w=%h d=%h want 1 00 00", c, vld_o, win_o, din_o);
      end
    end
    repeat (6) tick();
    acc_vld_i = 1'b1; acc_i = 8'h11;
    tick();
    acc_vld_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || result_o !== 8'h11) begin
      failures++;
      $display("FAIL abort_recover got done=%b res=%h want 1 11", done_o, result_o);
    end
    tick();
    $display("reset_abort: burst aborted, buffers cleared, result=%h", result_o);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_start_held();
    test_busy_writes();
    test_coincident();
    test_range();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
